// File: rtl/bomb_fuse_ctrl_if.sv
// Bomb-stage <-> fuse controller bundle: bomb placement/trigger in, explode pulse and blast
// description out to the bomb stage, color mapper and player-hit logic.
interface bomb_fuse_ctrl_if;
  logic       bomb_check;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic       detonate;
  logic       explode;
  logic       armed;
  logic       blink;
  logic       blast_active;
  logic [9:0] blastX;
  logic [9:0] blastY;
  logic [9:0] blast_reach;

  modport master (
    output bomb_check, bombX, bombY, detonate,
    input  explode, armed, blink, blast_active, blastX, blastY, blast_reach
  );

  modport slave (
    input  bomb_check, bombX, bombY, detonate,
    output explode, armed, blink, blast_active, blastX, blastY, blast_reach
  );
endinterface

// File: rtl/bomb_fuse_ctrl.sv
// Fuse timer and blast sequencer: IDLE -> ARMED -> BLAST -> COOLDOWN -> IDLE, one explode
// pulse per fuse, growing flame reach during BLAST. Every output is a flop.
module bomb_fuse_ctrl #(
  parameter logic [9:0] FUSE_FRAMES     = 10'd120,
  parameter logic [9:0] FAST_BLINK_AT   = 10'd30,
  parameter logic [9:0] BLAST_FRAMES    = 10'd30,
  parameter logic [9:0] COOLDOWN_FRAMES = 10'd6,
  parameter logic [9:0] GROW_STEP       = 10'd8,
  parameter logic [9:0] MAX_REACH       = 10'd64
) (
  input logic             frame_clk,
  input logic             Reset,
  bomb_fuse_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StBlast, StCooldown} state_e;

  state_e      state_q, state_d;
  logic [9:0]  fuse_cnt_q, fuse_cnt_d;
  logic [9:0]  phase_cnt_q, phase_cnt_d;
  logic [9:0]  reach_q, reach_d;
  logic [9:0]  blast_x_q, blast_x_d;
  logic [9:0]  blast_y_q, blast_y_d;
  logic        explode_q, explode_d;
  logic        armed_q, armed_d;
  logic        blink_q, blink_d;
  logic        active_q, active_d;
  logic [10:0] reach_sum;
  logic        fast_blink;

  always_comb begin
    state_d     = state_q;
    fuse_cnt_d  = fuse_cnt_q;
    phase_cnt_d = phase_cnt_q;
    reach_d     = reach_q;
    blast_x_d   = blast_x_q;
    blast_y_d   = blast_y_q;
    explode_d   = 1'b0;
    reach_sum   = {1'b0, reach_q} + {1'b0, GROW_STEP};

    unique case (state_q)
      StIdle: begin
        if (bus.bomb_check) begin
          blast_x_d  = bus.bombX;
          blast_y_d  = bus.bombY;
          fuse_cnt_d = 10'd0;
          state_d    = StArmed;
        end
      end
      StArmed: begin
        // Removal wins over a coincident trip: a vanished bomb never explodes.
        if (!bus.bomb_check) begin
          fuse_cnt_d = 10'd0;
          state_d    = StIdle;
        end else if ((fuse_cnt_q == FUSE_FRAMES - 10'd1) || bus.detonate) begin
          explode_d   = 1'b1;
          fuse_cnt_d  = 10'd0;
          phase_cnt_d = 10'd0;
          reach_d     = GROW_STEP;
          state_d     = StBlast;
        end else begin
          fuse_cnt_d = fuse_cnt_q + 10'd1;
        end
      end
      StBlast: begin
        if (phase_cnt_q == BLAST_FRAMES - 10'd1) begin
          phase_cnt_d = 10'd0;
          reach_d     = 10'd0;
          state_d     = StCooldown;
        end else begin
          phase_cnt_d = phase_cnt_q + 10'd1;
          reach_d     = (reach_sum > {1'b0, MAX_REACH}) ? MAX_REACH : reach_sum[9:0];
        end
      end
      StCooldown: begin
        if ((COOLDOWN_FRAMES == 10'd0) || (phase_cnt_q == COOLDOWN_FRAMES - 10'd1)) begin
          phase_cnt_d = 10'd0;
          state_d     = StIdle;
        end else begin
          phase_cnt_d = phase_cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from next state so they line up with the state they describe.
  always_comb begin
    armed_d    = (state_d == StArmed);
    active_d   = (state_d == StBlast);
    // remaining <= FAST_BLINK_AT, rearranged to avoid underflow; 11 bits cannot overflow.
    fast_blink = ({1'b0, fuse_cnt_d} + {1'b0, FAST_BLINK_AT} + 11'd1) >= {1'b0, FUSE_FRAMES};
    blink_d    = 1'b0;
    if (state_d == StArmed) begin
      blink_d = fast_blink ? fuse_cnt_d[1] : fuse_cnt_d[3];
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      fuse_cnt_q  <= 10'd0;
      phase_cnt_q <= 10'd0;
      reach_q     <= 10'd0;
      blast_x_q   <= 10'd0;
      blast_y_q   <= 10'd0;
      explode_q   <= 1'b0;
      armed_q     <= 1'b0;
      blink_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fuse_cnt_q  <= fuse_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      reach_q     <= reach_d;
      blast_x_q   <= blast_x_d;
      blast_y_q   <= blast_y_d;
      explode_q   <= explode_d;
      armed_q     <= armed_d;
      blink_q     <= blink_d;
      active_q    <= active_d;
    end
  end

  assign bus.explode      = explode_q;
  assign bus.armed        = armed_q;
  assign bus.blink        = blink_q;
  assign bus.blast_active = active_q;
  assign bus.blastX       = blast_x_q;
  assign bus.blastY       = blast_y_q;
  assign bus.blast_reach  = reach_q;

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Directed bench for bomb_fuse_ctrl: fuse latency, blast growth, cooldown re-arm, early
// detonation, bomb removal, async reset and blink cadence.
module tb_bomb_fuse_ctrl;
  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   n_checks  = 0;
  int   n_errs    = 0;
  int   pulses;

  bomb_fuse_ctrl_if bif ();

  bomb_fuse_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bif.slave)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    logic [9:0] kv;
    bif.bomb_check = 1'b0;
    bif.bombX      = 10'd0;
    bif.bombY      = 10'd0;
    bif.detonate   = 1'b0;

    // Reset state
    #3;
    check("rst_armed", bif.armed, 0);
    check("rst_explode", bif.explode, 0);
    check("rst_active", bif.blast_active, 0);
    check("rst_reach", bif.blast_reach, 0);
    check("rst_blastx", bif.blastX, 0);
    #4 Reset = 1'b0;

    // 1: arm at edge 0, single pulse at edge 120
    bif.bomb_check = 1'b1;
    bif.bombX = 10'd100;
    bif.bombY = 10'd200;
    tick();
    check("t1_armed_e0", bif.armed, 1);
    check("t1_blink_e0", bif.blink, 0);
    check("t1_blastx", bif.blastX, 100);
    check("t1_blasty", bif.blastY, 200);
    pulses = 0;
    for (int k = 1; k <= 119; k++) begin
      tick();
      if (bif.explode) pulses++;
    end
    check("t1_no_early_pulse", pulses, 0);
    check("t1_armed_e119", bif.armed, 1);
    tick();
    check("t1_explode_e120", bif.explode, 1);
    check("t1_armed_e120", bif.armed, 0);
    check("t1_active_e120", bif.blast_active, 1);
    check("t1_reach_e120", bif.blast_reach, 8);
    bif.bomb_check = 1'b0;
    bif.bombX = 10'd700;
    bif.bombY = 10'd500;

    // 2 + 5: growth, saturation, re-placement during blast
    pulses = 0;
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (bif.explode) pulses++;
      check("t2_reach", bif.blast_reach, (8 * (k + 1) > 64) ? 64 : 8 * (k + 1));
      check("t2_active", bif.blast_active, 1);
      if (k == 10) begin
        bif.bomb_check = 1'b1;
        bif.bombX = 10'd300;
        bif.bombY = 10'd40;
      end
    end
    check("t2_blastx_held", bif.blastX, 100);
    check("t2_blasty_held", bif.blastY, 200);
    check("t2_blink_blast", bif.blink, 0);
    tick();
    if (bif.explode) pulses++;
    check("t2_active_end", bif.blast_active, 0);
    check("t2_reach_end", bif.blast_reach, 0);
    for (int k = 31; k <= 36; k++) begin
      tick();
      if (bif.explode) pulses++;
      check("t5_no_arm_cooldown", bif.armed, 0);
      check("t6_blink_cooldown", bif.blink, 0);
    end
    check("t2_single_pulse", pulses, 0);
    tick();
    check("t5_rearm", bif.armed, 1);
    check("t5_blastx", bif.blastX, 300);
    check("t5_blasty", bif.blastY, 40);

    // 6: blink cadence over the new fuse
    pulses = 0;
    for (int k = 1; k <= 119; k++) begin
      tick();
      kv = 10'(k);
      if (bif.explode) pulses++;
      check("t6_blink", bif.blink, (k < 89) ? kv[3] : kv[1]);
    end
    check("t5_no_early_pulse", pulses, 0);
    tick();
    check("t5_explode_120", bif.explode, 1);
    check("t6_blink_off", bif.blink, 0);
    bif.bomb_check = 1'b0;
    tick();
    check("t5_pulse_one_frame", bif.explode, 0);
    for (int k = 0; k < 40; k++) tick();
    check("t6_blink_idle", bif.blink, 0);
    check("idle_active", bif.blast_active, 0);
    check("idle_armed", bif.armed, 0);

    // 3: early detonate at fuse_cnt=10
    bif.bomb_check = 1'b1;
    bif.bombX = 10'd5;
    bif.bombY = 10'd6;
    tick();
    for (int k = 1; k <= 10; k++) tick();
    check("t3_no_pulse_yet", bif.explode, 0);
    bif.detonate = 1'b1;
    tick();
    check("t3_explode", bif.explode, 1);
    check("t3_active", bif.blast_active, 1);
    bif.detonate = 1'b0;
    pulses = 0;
    for (int k = 12; k <= 130; k++) begin
      tick();
      if (bif.explode) pulses++;
    end
    check("t3_no_second_pulse", pulses, 0);

    // bomb removed while armed
    check("rm_armed_before", bif.armed, 1);
    bif.bomb_check = 1'b0;
    tick();
    check("rm_disarm", bif.armed, 0);
    pulses = 0;
    for (int k = 0; k < 130; k++) begin
      tick();
      if (bif.explode) pulses++;
    end
    check("rm_no_pulse", pulses, 0);

    // 4: async reset mid-fuse
    bif.bomb_check = 1'b1;
    bif.bombX = 10'd77;
    bif.bombY = 10'd88;
    tick();
    for (int k = 1; k <= 50; k++) tick();
    check("t4_armed_before", bif.armed, 1);
    check("t4_blastx_before", bif.blastX, 77);
    #2 Reset = 1'b1;
    #1;
    check("t4_armed", bif.armed, 0);
    check("t4_blastx", bif.blastX, 0);
    check("t4_blasty", bif.blastY, 0);
    check("t4_blink", bif.blink, 0);
    check("t4_explode", bif.explode, 0);
    bif.bomb_check = 1'b0;
    #1 Reset = 1'b0;
    bif.detonate = 1'b1;
    pulses = 0;
    for (int k = 0; k < 130; k++) begin
      tick();
      if (bif.explode) pulses++;
    end
    check("t4_no_pulse_after", pulses, 0);
    check("t4_idle_armed", bif.armed, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
